mesi_req_sched: RTL and testbench
=================================

MESI_REQ_SCHED -- requirements
Module: mesi_req_sched

Interface
REQ-001 Parameter SNP_STREAK_MAX, default 4: maximum consecutive snoop grants while a CPU request is waiting.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_valid  input  1  CPU request pending.
REQ-005 cpu_ready  output  1  CPU request accepted this cycle.
REQ-006 cpu_wr  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  CPU request address.
REQ-008 cpu_done  output  1  one-cycle pulse when the accepted CPU request completes.
REQ-009 snp_valid / snp_ready  input / output  1 / 1  snoop request handshake.
REQ-010 snp_op  input  bus_operation_e  snooped bus operation.
REQ-011 snp_addr  input  32  snooped address.
REQ-012 snp_result  output  snoop_result_e  snoop response; valid only while snp_result_valid is high.
REQ-013 snp_result_valid  output  1  one-cycle pulse.
REQ-014 arr_rd_en / arr_wr_en  output / output  1 / 1  tag/MESI array read and write strobes.
REQ-015 arr_addr  output  32  array address.
REQ-016 arr_hit, arr_state, arr_victim_state, arr_victim_addr  input  1, mesi_e, mesi_e, 32  array read data, valid the cycle after arr_rd_en.
REQ-017 arr_wr_state  output  mesi_e  new line state; written when arr_wr_en is high.
REQ-018 bus_valid  output  1  bus request; held until bus_done.
REQ-019 bus_op  output  bus_operation_e  requested bus operation.
REQ-020 bus_addr  output  32  bus request address.
REQ-021 bus_done  input  1  bus transaction complete.
REQ-022 bus_copy  input  1  C signal; sampled with bus_done.

Function
REQ-023 FSM states: IDLE, LOOKUP, EVICT, BUSOP, UPDATE. Exactly one request is in flight at a time.
REQ-024 IDLE, arbitration:
- Snoop wins by default.
- CPU wins if cpu_valid is high and the snoop streak counter equals SNP_STREAK_MAX.
REQ-025 Grant:
- Assert cpu_ready or snp_ready (never both) for exactly one cycle.
- Latch op, address and requester.
- Drive arr_rd_en that cycle.
- Go to LOOKUP.
REQ-026 Snoop streak counter:
- Increments on a snoop grant made while cpu_valid is high.
- Saturates at SNP_STREAK_MAX.
- Clears on any CPU grant.
REQ-027 Snoop, in LOOKUP (single cycle):
- Miss, or snp_op WRITE: snp_result = NOHIT, no array write.
- READ hit in M: snp_result = HITM, write S.
- READ hit in E or S: snp_result = HIT, write S.
- RWIM or INVALIDATE hit: HITM if the line was M, else HIT; write I.
- Then go to UPDATE. Snoops never drive bus_valid.
REQ-028 CPU read hit: no state change; cpu_done is asserted in UPDATE, 2 cycles after grant.
REQ-029 CPU write hit:
- In E or M: write M with no bus operation.
- In S: issue bus INVALIDATE, then write M.
REQ-030 CPU miss with arr_victim_state == M: go to EVICT and issue bus WRITE to arr_victim_addr; wait for bus_done, then go to BUSOP.
REQ-031 CPU miss with any other victim: go directly to BUSOP.
REQ-032 BUSOP:
- Read miss: bus READ to the latched address; on bus_done write S if bus_copy is 1, else E.
- Write miss: bus RWIM; on bus_done write M.
REQ-033 UPDATE (one cycle):
- Drive arr_wr_en when a state change is required.
- Pulse cpu_done or snp_result_valid.
- Return to IDLE.
REQ-034 bus_op, bus_addr and bus_valid stay stable from assertion until the cycle bus_done is sampled high. bus_done outside EVICT/BUSOP is ignored.
REQ-035 Simultaneous cpu_valid and snp_valid in IDLE: rule REQ-024 applies; the loser waits and its inputs must stay stable.
REQ-036 arr_rd_en and arr_wr_en are never high in the same cycle.

Reset
REQ-037 While rst is high:
- FSM is IDLE and the streak counter is 0.
- All handshake, strobe and pulse outputs are 0.
- bus_op = READ, snp_result = NOHIT, arr_wr_state = I, addresses are 0.
REQ-038 Reset mid-transaction abandons the request with no array write and no completion pulse.

Structure
REQ-039 pkg_bus holds bus_operation_e and snoop_result_e; pkg_line holds mesi_e.
REQ-040 The FSM state enum and the SNP_STREAK_MAX default live in pkg_bus.
REQ-041 A single sub-module, req_arbiter, implements REQ-024 to REQ-026; everything else is flat.

Verification
REQ-042 CPU read 0x0000_1000 misses, victim I, bus_copy = 0 -> bus READ 0x1000, arr_wr_state = E, cpu_done 1 cycle after bus_done.
REQ-043 CPU write misses, victim M at 0x0002_0040 -> bus WRITE 0x20040, then RWIM to the request address, then write M.
REQ-044 Snoop READ hits a line in M -> snp_result = HITM, arr_wr_state = S, no bus_valid.
REQ-045 cpu_valid and snp_valid held high continuously -> grant pattern of 4 snoops then 1 CPU, repeating.
REQ-046 CPU write hits a line in S -> bus INVALIDATE, then M.
REQ-047 rst asserted while in BUSOP -> all outputs 0/IDLE next edge, no cpu_done, and the next request is serviced normally.

Source files
------------

// File: rtl/pkg_bus.sv
// Bus operations, snoop responses and scheduler
// FSM states for the MESI request scheduler.
package pkg_bus;

  typedef enum logic [1:0] {
    BUS_READ  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_RWIM  = 2'd2,
    BUS_INV   = 2'd3
  } bus_operation_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_result_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_BUSOP,
    ST_UPDATE
  } state_e;

  localparam int SNP_STREAK_MAX_DEF = 4;

endpackage

// File: rtl/pkg_line.sv
// Cache line coherence state shared by the
// MESI request scheduler and its tag array.
package pkg_line;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

endpackage

// File: rtl/mesi_req_sched_if.sv
// CPU, snoop, tag-array and bus signal bundle
// of the MESI request scheduler.
interface mesi_req_sched_if
  import pkg_bus::*, pkg_line::*;
;
  logic           cpu_valid;
  logic           cpu_ready;
  logic           cpu_wr;
  logic [31:0]    cpu_addr;
  logic           cpu_done;

  logic           snp_valid;
  logic           snp_ready;
  bus_operation_e snp_op;
  logic [31:0]    snp_addr;
  snoop_result_e  snp_result;
  logic           snp_result_valid;

  logic           arr_rd_en;
  logic           arr_wr_en;
  logic [31:0]    arr_addr;
  logic           arr_hit;
  mesi_e          arr_state;
  mesi_e          arr_victim_state;
  logic [31:0]    arr_victim_addr;
  mesi_e          arr_wr_state;

  logic           bus_valid;
  bus_operation_e bus_op;
  logic [31:0]    bus_addr;
  logic           bus_done;
  logic           bus_copy;

  modport slave (
    input  cpu_valid, cpu_wr, cpu_addr,
    input  snp_valid, snp_op, snp_addr,
    input  arr_hit, arr_state,
    input  arr_victim_state, arr_victim_addr,
    input  bus_done, bus_copy,
    output cpu_ready, cpu_done,
    output snp_ready, snp_result,
    output snp_result_valid,
    output arr_rd_en, arr_wr_en,
    output arr_addr, arr_wr_state,
    output bus_valid, bus_op, bus_addr
  );

  modport master (
    output cpu_valid, cpu_wr, cpu_addr,
    output snp_valid, snp_op, snp_addr,
    output arr_hit, arr_state,
    output arr_victim_state, arr_victim_addr,
    output bus_done, bus_copy,
    input  cpu_ready, cpu_done,
    input  snp_ready, snp_result,
    input  snp_result_valid,
    input  arr_rd_en, arr_wr_en,
    input  arr_addr, arr_wr_state,
    input  bus_valid, bus_op, bus_addr
  );

endinterface

// File: rtl/req_arbiter.sv
// Snoop-first arbiter with a bounded snoop streak
// so a waiting CPU request cannot starve.
module req_arbiter
  import pkg_bus::*;
#(
  parameter int SNP_STREAK_MAX = SNP_STREAK_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cpu_valid,
  input  logic snp_valid,
  output logic cpu_grant,
  output logic snp_grant
);

  localparam int CW = $clog2(SNP_STREAK_MAX + 1);
  localparam logic [CW-1:0] MAXV =
    CW'(SNP_STREAK_MAX);

  logic [CW-1:0] cnt_q;
  logic          starved;

  assign starved   = (cnt_q == MAXV);
  assign cpu_grant = en && cpu_valid &&
                     (!snp_valid || starved);
  assign snp_grant = en && snp_valid && !cpu_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cpu_grant) begin
      cnt_q <= '0;
    end else if (snp_grant && cpu_valid && !starved) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mesi_req_sched.sv
// Single-outstanding MESI request scheduler: arbitrates
// CPU and snoop requests, walks lookup/evict/bus/update.
module mesi_req_sched
  import pkg_bus::*, pkg_line::*;
#(
  parameter int SNP_STREAK_MAX = SNP_STREAK_MAX_DEF
) (
  input logic             clk,
  input logic             rst,
  mesi_req_sched_if.slave io
);

  state_e         st_q, st_d;
  logic           req_cpu_q, req_cpu_d;
  logic           req_wr_q, req_wr_d;
  bus_operation_e req_op_q, req_op_d;
  logic [31:0]    req_addr_q, req_addr_d;
  logic           wr_need_q, wr_need_d;
  mesi_e          wr_st_q, wr_st_d;
  snoop_result_e  res_q, res_d;
  bus_operation_e bop_q, bop_d;
  logic [31:0]    baddr_q, baddr_d;

  logic        cpu_grant, snp_grant, arb_en;
  logic        rd_en, wr_en, done_cpu, done_snp;
  logic [31:0] arr_addr;

  assign arb_en = (st_q == ST_IDLE) && !rst;

  req_arbiter #(
    .SNP_STREAK_MAX(SNP_STREAK_MAX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .cpu_valid (io.cpu_valid),
    .snp_valid (io.snp_valid),
    .cpu_grant (cpu_grant),
    .snp_grant (snp_grant)
  );

  assign io.cpu_ready        = cpu_grant;
  assign io.snp_ready        = snp_grant;
  assign io.cpu_done         = done_cpu;
  assign io.snp_result_valid = done_snp;
  assign io.snp_result       = res_q;
  assign io.arr_rd_en        = rd_en;
  assign io.arr_wr_en        = wr_en;
  assign io.arr_addr         = arr_addr;
  assign io.arr_wr_state     = wr_st_q;
  assign io.bus_op           = bop_q;
  assign io.bus_addr         = baddr_q;
  assign io.bus_valid        = (st_q == ST_EVICT) ||
                               (st_q == ST_BUSOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d       = st_q;
    req_cpu_d  = req_cpu_q;
    req_wr_d   = req_wr_q;
    req_op_d   = req_op_q;
    req_addr_d = req_addr_q;
    wr_need_d  = wr_need_q;
    wr_st_d    = wr_st_q;
    res_d      = res_q;
    bop_d      = bop_q;
    baddr_d    = baddr_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    done_cpu   = 1'b0;
    done_snp   = 1'b0;
    arr_addr   = req_addr_q;
    unique case (st_q)
      ST_IDLE: begin
        if (cpu_grant || snp_grant) begin
          rd_en      = 1'b1;
          st_d       = ST_LOOKUP;
          req_cpu_d  = cpu_grant;
          req_wr_d   = io.cpu_wr;
          req_op_d   = io.snp_op;
          req_addr_d = cpu_grant ? io.cpu_addr
                                 : io.snp_addr;
          wr_need_d  = 1'b0;
          arr_addr   = req_addr_d;
        end
      end
      ST_LOOKUP: begin
        st_d = ST_UPDATE;
        if (!req_cpu_q) begin
          res_d = SNP_NOHIT;
          if (io.arr_hit) begin
            unique case (req_op_q)
              BUS_READ: begin
                res_d     = (io.arr_state == MESI_M) ?
                            SNP_HITM : SNP_HIT;
                wr_need_d = 1'b1;
                wr_st_d   = MESI_S;
              end
              BUS_RWIM, BUS_INV: begin
                res_d     = (io.arr_state == MESI_M) ?
                            SNP_HITM : SNP_HIT;
                wr_need_d = 1'b1;
                wr_st_d   = MESI_I;
              end
              default: ;
            endcase
          end
        end else if (io.arr_hit) begin
          // shared write hit must invalidate peers first
          if (req_wr_q && io.arr_state == MESI_S) begin
            st_d    = ST_BUSOP;
            bop_d   = BUS_INV;
            baddr_d = req_addr_q;
          end else if (req_wr_q) begin
            wr_need_d = 1'b1;
            wr_st_d   = MESI_M;
          end
        end else if (io.arr_victim_state == MESI_M) begin
          st_d    = ST_EVICT;
          bop_d   = BUS_WRITE;
          baddr_d = io.arr_victim_addr;
        end else begin
          st_d    = ST_BUSOP;
          bop_d   = req_wr_q ? BUS_RWIM : BUS_READ;
          baddr_d = req_addr_q;
        end
      end
      ST_EVICT: begin
        if (io.bus_done) begin
          st_d    = ST_BUSOP;
          bop_d   = req_wr_q ? BUS_RWIM : BUS_READ;
          baddr_d = req_addr_q;
        end
      end
      ST_BUSOP: begin
        if (io.bus_done) begin
          st_d      = ST_UPDATE;
          wr_need_d = 1'b1;
          if (bop_q == BUS_READ)
            wr_st_d = io.bus_copy ? MESI_S : MESI_E;
          else
            wr_st_d = MESI_M;
        end
      end
      ST_UPDATE: begin
        wr_en    = wr_need_q;
        done_cpu = req_cpu_q;
        done_snp = !req_cpu_q;
        st_d     = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cpu_q  <= 1'b0;
      req_wr_q   <= 1'b0;
      req_op_q   <= BUS_READ;
      req_addr_q <= '0;
      wr_need_q  <= 1'b0;
      wr_st_q    <= MESI_I;
      res_q      <= SNP_NOHIT;
      bop_q      <= BUS_READ;
      baddr_q    <= '0;
    end else begin
      req_cpu_q  <= req_cpu_d;
      req_wr_q   <= req_wr_d;
      req_op_q   <= req_op_d;
      req_addr_q <= req_addr_d;
      wr_need_q  <= wr_need_d;
      wr_st_q    <= wr_st_d;
      res_q      <= res_d;
      bop_q      <= bop_d;
      baddr_q    <= baddr_d;
    end
  end

endmodule

// File: tb/tb_mesi_req_sched.sv
// Scoreboard bench for mesi_req_sched: directed
// requests push expectations, a monitor pops them.
module tb_mesi_req_sched;
  import pkg_bus::*, pkg_line::*;

  typedef struct {
    bus_operation_e op;
    logic [31:0]    addr;
  } busreq_t;

  typedef struct {
    mesi_e       st;
    logic [31:0] addr;
  } wr_t;

  typedef struct {
    logic          is_cpu;
    snoop_result_e res;
    int            lat;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesi_req_sched_if io();

  mesi_req_sched #(
    .SNP_STREAK_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int checks = 0;
  int errors = 0;

  logic    q_grant[$];
  busreq_t q_bus[$];
  wr_t     q_wr[$];
  done_t   q_done[$];

  int cyc, grant_cyc, bdone_cyc;
  int grant_cnt, done_cnt, bn;
  logic bus_hold;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               name, got, exp);
    end
  endtask

  task automatic eg(input logic c);
    q_grant.push_back(c);
  endtask

  task automatic eb(input bus_operation_e op,
                    input logic [31:0] a);
    busreq_t b;
    b.op = op;
    b.addr = a;
    q_bus.push_back(b);
  endtask

  task automatic ew(input mesi_e st,
                    input logic [31:0] a);
    wr_t w;
    w.st = st;
    w.addr = a;
    q_wr.push_back(w);
  endtask

  task automatic ed(input logic c,
                    input snoop_result_e r,
                    input int l);
    done_t d;
    d.is_cpu = c;
    d.res = r;
    d.lat = l;
    q_done.push_back(d);
  endtask

  // monitor / scoreboard
  initial begin : mon
    busreq_t        b;
    wr_t            w;
    done_t          d;
    logic           pv, pd;
    bus_operation_e p_op;
    logic [31:0]    paddr;
    cyc = 0;
    grant_cyc = 0;
    bdone_cyc = 0;
    grant_cnt = 0;
    done_cnt = 0;
    pv = 1'b0;
    pd = 1'b0;
    p_op = BUS_READ;
    paddr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pv = 1'b0;
        pd = 1'b0;
      end else begin
        chk("excl",
            {30'd0, io.cpu_ready & io.snp_ready,
             io.arr_rd_en & io.arr_wr_en}, 0);
        if (io.cpu_ready || io.snp_ready) begin
          grant_cnt++;
          grant_cyc = cyc;
          chk("grant_rd_en", io.arr_rd_en, 1);
          chk("grant_addr", io.arr_addr,
              io.cpu_ready ? io.cpu_addr
                           : io.snp_addr);
          if (q_grant.size() == 0)
            chk("grant_unexp", 1, 0);
          else
            chk("grant_who", io.cpu_ready,
                q_grant.pop_front());
        end
        if (io.bus_valid) begin
          if (!pv || pd) begin
            if (q_bus.size() == 0) begin
              chk("bus_unexp", 1, 0);
            end else begin
              b = q_bus.pop_front();
              chk("bus_op", io.bus_op, b.op);
              chk("bus_addr", io.bus_addr, b.addr);
            end
          end else begin
            chk("bus_op_stable", io.bus_op, p_op);
            chk("bus_addr_stable", io.bus_addr, paddr);
          end
          if (io.bus_done) bdone_cyc = cyc;
        end
        if (io.arr_wr_en) begin
          if (q_wr.size() == 0) begin
            chk("wr_unexp", 1, 0);
          end else begin
            w = q_wr.pop_front();
            chk("wr_state", io.arr_wr_state, w.st);
            chk("wr_addr", io.arr_addr, w.addr);
          end
        end
        if (io.cpu_done || io.snp_result_valid) begin
          done_cnt++;
          if (q_done.size() == 0) begin
            chk("done_unexp", 1, 0);
          end else begin
            d = q_done.pop_front();
            chk("done_who", io.cpu_done, d.is_cpu);
            if (!d.is_cpu)
              chk("snp_result", io.snp_result, d.res);
            chk("done_lat",
                cyc - ((d.lat == 2) ? grant_cyc
                                    : bdone_cyc),
                d.lat);
          end
        end
        pv = io.bus_valid;
        pd = io.bus_valid & io.bus_done;
        p_op = io.bus_op;
        paddr = io.bus_addr;
      end
    end
  end

  // bus responder: completes after 3 valid cycles
  initial begin
    bn = 0;
    io.bus_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      io.bus_done = 1'b0;
      if (io.bus_valid && !bus_hold) begin
        bn++;
        if (bn == 3) begin
          io.bus_done = 1'b1;
          bn = 0;
        end
      end else begin
        bn = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic set_arr(input logic hit,
                         input mesi_e st,
                         input mesi_e vst,
                         input logic [31:0] va,
                         input logic cp);
    io.arr_hit = hit;
    io.arr_state = st;
    io.arr_victim_state = vst;
    io.arr_victim_addr = va;
    io.bus_copy = cp;
  endtask

  task automatic wait_done(input int tgt);
    int t;
    t = 0;
    while (done_cnt < tgt && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done_cnt >= tgt), 1);
  endtask

  task automatic cpu_req(input logic wr,
                         input logic [31:0] a);
    int tgt, t;
    tgt = done_cnt + 1;
    t = 0;
    @(posedge clk);
    #1;
    io.cpu_wr = wr;
    io.cpu_addr = a;
    io.cpu_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!io.cpu_ready && t < 50);
    chk("cpu_grant_seen", io.cpu_ready, 1);
    @(posedge clk);
    #1;
    io.cpu_valid = 1'b0;
    wait_done(tgt);
  endtask

  task automatic snp_req(input bus_operation_e op,
                         input logic [31:0] a);
    int tgt, t;
    tgt = done_cnt + 1;
    t = 0;
    @(posedge clk);
    #1;
    io.snp_op = op;
    io.snp_addr = a;
    io.snp_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!io.snp_ready && t < 50);
    chk("snp_grant_seen", io.snp_ready, 1);
    @(posedge clk);
    #1;
    io.snp_valid = 1'b0;
    wait_done(tgt);
  endtask

  task automatic chk_rst_outs();
    chk("rst_cpu_ready", io.cpu_ready, 0);
    chk("rst_snp_ready", io.snp_ready, 0);
    chk("rst_cpu_done", io.cpu_done, 0);
    chk("rst_snp_rv", io.snp_result_valid, 0);
    chk("rst_rd_en", io.arr_rd_en, 0);
    chk("rst_wr_en", io.arr_wr_en, 0);
    chk("rst_bus_valid", io.bus_valid, 0);
    chk("rst_bus_op", io.bus_op, BUS_READ);
    chk("rst_snp_result", io.snp_result, SNP_NOHIT);
    chk("rst_wr_state", io.arr_wr_state, MESI_I);
    chk("rst_arr_addr", io.arr_addr, 0);
    chk("rst_bus_addr", io.bus_addr, 0);
  endtask

  initial begin : stim
    int tg, td, t;
    bus_hold = 1'b0;
    rst = 1'b1;
    io.cpu_valid = 1'b1;
    io.snp_valid = 1'b1;
    io.cpu_wr = 1'b0;
    io.cpu_addr = 32'h44;
    io.snp_op = BUS_READ;
    io.snp_addr = 32'h88;
    set_arr(1'b0, MESI_I, MESI_I, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk_rst_outs();
    io.cpu_valid = 1'b0;
    io.snp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // read miss, clean victim, no sharers
    eg(1); eb(BUS_READ, 32'h1000);
    ew(MESI_E, 32'h1000); ed(1, SNP_NOHIT, 1);
    set_arr(0, MESI_I, MESI_I, '0, 0);
    cpu_req(0, 32'h1000);

    // read miss with sharers
    eg(1); eb(BUS_READ, 32'h3000);
    ew(MESI_S, 32'h3000); ed(1, SNP_NOHIT, 1);
    set_arr(0, MESI_I, MESI_E, 32'h3f00, 1);
    cpu_req(0, 32'h3000);

    // write miss, dirty victim
    eg(1); eb(BUS_WRITE, 32'h0002_0040);
    eb(BUS_RWIM, 32'h5000_0080);
    ew(MESI_M, 32'h5000_0080); ed(1, SNP_NOHIT, 1);
    set_arr(0, MESI_I, MESI_M, 32'h0002_0040, 0);
    cpu_req(1, 32'h5000_0080);

    // snoops
    eg(0); ew(MESI_S, 32'h7000); ed(0, SNP_HITM, 2);
    set_arr(1, MESI_M, MESI_I, '0, 0);
    snp_req(BUS_READ, 32'h7000);

    eg(0); ew(MESI_S, 32'h7100); ed(0, SNP_HIT, 2);
    set_arr(1, MESI_E, MESI_I, '0, 0);
    snp_req(BUS_READ, 32'h7100);

    eg(0); ew(MESI_S, 32'h7180); ed(0, SNP_HIT, 2);
    set_arr(1, MESI_S, MESI_I, '0, 0);
    snp_req(BUS_READ, 32'h7180);

    eg(0); ew(MESI_I, 32'h7200); ed(0, SNP_HITM, 2);
    set_arr(1, MESI_M, MESI_I, '0, 0);
    snp_req(BUS_RWIM, 32'h7200);

    eg(0); ew(MESI_I, 32'h7300); ed(0, SNP_HIT, 2);
    set_arr(1, MESI_S, MESI_I, '0, 0);
    snp_req(BUS_INV, 32'h7300);

    eg(0); ed(0, SNP_NOHIT, 2);
    set_arr(0, MESI_I, MESI_M, 32'h9990, 0);
    snp_req(BUS_READ, 32'h7400);

    eg(0); ed(0, SNP_NOHIT, 2);
    set_arr(1, MESI_M, MESI_I, '0, 0);
    snp_req(BUS_WRITE, 32'h7500);

    // CPU hits
    eg(1); ed(1, SNP_NOHIT, 2);
    set_arr(1, MESI_E, MESI_I, '0, 0);
    cpu_req(0, 32'h8000);

    eg(1); ew(MESI_M, 32'h8100); ed(1, SNP_NOHIT, 2);
    set_arr(1, MESI_E, MESI_I, '0, 0);
    cpu_req(1, 32'h8100);

    eg(1); ew(MESI_M, 32'h8200); ed(1, SNP_NOHIT, 2);
    set_arr(1, MESI_M, MESI_I, '0, 0);
    cpu_req(1, 32'h8200);

    eg(1); eb(BUS_INV, 32'h8300);
    ew(MESI_M, 32'h8300); ed(1, SNP_NOHIT, 1);
    set_arr(1, MESI_S, MESI_I, '0, 0);
    cpu_req(1, 32'h8300);

    eg(1); eb(BUS_RWIM, 32'h8400);
    ew(MESI_M, 32'h8400); ed(1, SNP_NOHIT, 1);
    set_arr(0, MESI_I, MESI_S, 32'h8f00, 0);
    cpu_req(1, 32'h8400);

    // both requesters held: 4 snoops then 1 CPU
    set_arr(1, MESI_S, MESI_I, '0, 0);
    io.cpu_wr = 1'b0;
    io.cpu_addr = 32'hC000;
    io.snp_op = BUS_WRITE;
    io.snp_addr = 32'hD000;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) begin
        eg(1); ed(1, SNP_NOHIT, 2);
      end else begin
        eg(0); ed(0, SNP_NOHIT, 2);
      end
    end
    tg = grant_cnt + 10;
    td = done_cnt + 10;
    @(posedge clk);
    #1;
    io.cpu_valid = 1'b1;
    io.snp_valid = 1'b1;
    t = 0;
    while (grant_cnt < tg && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("streak_grants", grant_cnt, tg);
    @(posedge clk);
    #1;
    io.cpu_valid = 1'b0;
    io.snp_valid = 1'b0;
    wait_done(td);

    // reset while the bus read is outstanding
    bus_hold = 1'b1;
    eg(1); eb(BUS_READ, 32'h9000);
    set_arr(0, MESI_I, MESI_I, '0, 0);
    @(posedge clk);
    #1;
    io.cpu_wr = 1'b0;
    io.cpu_addr = 32'h9000;
    io.cpu_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!io.cpu_ready && t < 50);
    chk("rst_grant_seen", io.cpu_ready, 1);
    @(posedge clk);
    #1;
    io.cpu_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!io.bus_valid && t < 50);
    chk("busop_reached", io.bus_valid, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_rst_outs();
    @(negedge clk);
    chk_rst_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_hold = 1'b0;

    eg(1); eb(BUS_READ, 32'hA000);
    ew(MESI_S, 32'hA000); ed(1, SNP_NOHIT, 1);
    set_arr(0, MESI_I, MESI_I, '0, 1);
    cpu_req(0, 32'hA000);

    repeat (5) @(negedge clk);
    chk("q_empty",
        q_grant.size() + q_bus.size() +
        q_wr.size() + q_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
